// File: rtl/interrupt_request_unit.sv
// Interrupt request unit: edge-detects external lines, latches pending, masks and
// arbitrates by fixed priority toward the interrupt controller. Optional macro: IRQ_SYNC_EN.
module interrupt_request_unit #(
  parameter int                  NUM_IRQ  = 4,
  parameter int                  ID_W     = 2,
  parameter logic [NUM_IRQ-1:0]  MASK_RST = {NUM_IRQ{1'b0}}
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_IRQ-1:0] irq_in,
  input  logic               mask_wr,
  input  logic [NUM_IRQ-1:0] mask_wdata,
  input  logic               int_ack,
  input  logic               int_done,
  output logic               interrupt_signal,
  output logic [ID_W-1:0]    irq_id,
  output logic [NUM_IRQ-1:0] irq_pending,
  output logic [NUM_IRQ-1:0] irq_mask,
  output logic               in_service
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic                 int_q, int_d;
  logic [ID_W-1:0]      id_q, id_d;
  logic                 svc_q, svc_d;
  logic [NUM_IRQ-1:0]   pending_q, pending_d;
  logic [NUM_IRQ-1:0]   mask_q, mask_d;
  logic [NUM_IRQ-1:0]   hist_q;
  logic [NUM_IRQ-1:0]   line_s;
  logic [NUM_IRQ-1:0]   edge_s;
  logic [NUM_IRQ-1:0]   elig_s;
  logic [NUM_IRQ-1:0]   id_onehot_s;
  logic [NUM_IRQ-1:0]   clr_s;
  logic                 cur_elig_s;
  logic [ID_W-1:0]      winner_s;

  function automatic logic [ID_W-1:0] lowest_idx(input logic [NUM_IRQ-1:0] v);
    logic [ID_W-1:0] r;
    r = {ID_W{1'b0}};
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (v[i]) begin
        r = ID_W'(i);
      end else begin
        r = r;
      end
    end
    return r;
  endfunction

`ifdef IRQ_SYNC_EN
  logic [NUM_IRQ-1:0] sync1_q, sync2_q;

  // Two-flop synchronizer for the asynchronous request lines
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= {NUM_IRQ{1'b0}};
      sync2_q <= {NUM_IRQ{1'b0}};
    end else begin
      sync1_q <= irq_in;
      sync2_q <= sync1_q;
    end
  end

  assign line_s = sync2_q;
`else
  assign line_s = irq_in;
`endif

  assign edge_s   = line_s & ~hist_q;
  assign elig_s   = pending_q & mask_q;
  assign winner_s = lowest_idx(elig_s);

  // One-hot of the frozen request id, used for eligibility and ack clearing
  always_comb begin
    id_onehot_s = {NUM_IRQ{1'b0}};
    for (int i = 0; i < NUM_IRQ; i++) begin
      id_onehot_s[i] = (id_q == ID_W'(i));
    end
  end

  assign cur_elig_s = |(elig_s & id_onehot_s);

  // Request/service state machine: next state and output-register values
  always_comb begin
    state_d = state_q;
    int_d   = int_q;
    id_d    = id_q;
    svc_d   = svc_q;
    clr_s   = {NUM_IRQ{1'b0}};
    case (state_q)
      IDLE: begin
        if (|elig_s) begin
          state_d = REQ;
          id_d    = winner_s;
          int_d   = 1'b1;
        end else begin
          int_d   = 1'b0;
        end
      end
      REQ: begin
        if (int_ack) begin
          clr_s   = id_onehot_s;
          svc_d   = 1'b1;
          int_d   = 1'b0;
          state_d = SERVICE;
        end else if (!cur_elig_s) begin
          int_d   = 1'b0;
          state_d = IDLE;
        end else begin
          int_d   = 1'b1;
        end
      end
      SERVICE: begin
        int_d = 1'b0;
        if (int_done) begin
          svc_d   = 1'b0;
          state_d = IDLE;
        end else begin
          svc_d   = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        int_d   = 1'b0;
        svc_d   = 1'b0;
      end
    endcase
  end

  // A new edge wins over an ack clear on the same bit
  always_comb begin
    pending_d = (pending_q & ~clr_s) | edge_s;
    if (mask_wr) begin
      mask_d = mask_wdata;
    end else begin
      mask_d = mask_q;
    end
  end

  // State, status and edge-history registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      int_q     <= 1'b0;
      id_q      <= {ID_W{1'b0}};
      svc_q     <= 1'b0;
      pending_q <= {NUM_IRQ{1'b0}};
      mask_q    <= MASK_RST;
      hist_q    <= {NUM_IRQ{1'b0}};
    end else begin
      state_q   <= state_d;
      int_q     <= int_d;
      id_q      <= id_d;
      svc_q     <= svc_d;
      pending_q <= pending_d;
      mask_q    <= mask_d;
      hist_q    <= line_s;
    end
  end

  assign interrupt_signal = int_q;
  assign irq_id           = id_q;
  assign irq_pending      = pending_q;
  assign irq_mask         = mask_q;
  assign in_service       = svc_q;

endmodule
